// File: rtl/idma_burst_responder.sv
// Stand-in iDMA backend: buffers 1D burst requests and retires them at a fixed
// byte rate, emitting one trans_complete pulse per request in order.

package idma_burst_responder_pkg;
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] num_bytes;
  } burst_req_t;

  typedef struct packed {
    logic trans_complete;
    logic backend_idle;
  } meta_t;
endpackage

module idma_burst_responder #(
  parameter int unsigned ReqFifoDepth  = 2,
  parameter int unsigned BytesPerCycle = 4,
  parameter int unsigned SetupLatency  = 1,
  parameter int unsigned NumBytesWidth = 32,
  parameter type burst_req_t = idma_burst_responder_pkg::burst_req_t,
  parameter type meta_t      = idma_burst_responder_pkg::meta_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  burst_req_t  burst_req_i,
  input  logic        valid_i,
  output logic        ready_o,
  output meta_t       meta_o,
  input  logic        stall_i,
  output logic [31:0] trans_count_o
);

  localparam int unsigned PtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);
  localparam int unsigned SetW = (SetupLatency > 0) ? $clog2(SetupLatency + 1) : 1;

  typedef enum logic [1:0] {Idle, Setup, Xfer, Done} state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO (non-fall-through: an entry is visible the cycle after push)
  // ---------------------------------------------------------------------------
  burst_req_t      mem_q [ReqFifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            fifo_full, fifo_empty, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ReqFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == CntW'(ReqFifoDepth));
  assign fifo_empty = (cnt_q == '0);
  assign ready_o    = !fifo_full;
  assign push       = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= burst_req_i;
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [NumBytesWidth-1:0] rem_q, rem_d, rem_step, head_bytes;
  logic [SetW-1:0]          set_q, set_d;
  logic [31:0]              count_q;

  assign head_bytes = NumBytesWidth'(mem_q[rd_ptr_q].num_bytes);
  assign rem_step   = (rem_q <= NumBytesWidth'(BytesPerCycle)) ? '0
                    : rem_q - NumBytesWidth'(BytesPerCycle);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    set_d   = set_q;
    pop     = 1'b0;
    unique case (state_q)
      // DONE shares the dispatch path with IDLE so back-to-back requests
      // do not pay an extra idle cycle.
      Idle, Done: begin
        if (state_q == Done) state_d = Idle;
        if (!fifo_empty) begin
          pop   = 1'b1;
          rem_d = head_bytes;
          set_d = SetW'(SetupLatency);
          if (SetupLatency != 0)    state_d = Setup;
          else if (head_bytes == '0) state_d = Done;
          else                       state_d = Xfer;
        end
      end
      Setup: begin
        if (set_q <= SetW'(1)) state_d = (rem_q == '0) ? Done : Xfer;
        else                   set_d   = set_q - 1'b1;
      end
      Xfer: begin
        if (!stall_i) begin
          rem_d = rem_step;
          if (rem_step == '0) state_d = Done;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Idle;
      rem_q   <= '0;
      set_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      set_q   <= set_d;
      if (state_q == Done) count_q <= count_q + 32'd1;
    end
  end

  // Status is derived from registered state only; valid_i never reaches meta_o.
  always_comb begin
    meta_o                = '0;
    meta_o.trans_complete = (state_q == Done);
    meta_o.backend_idle   = (state_q == Idle) && fifo_empty;
  end

  assign trans_count_o = count_q;

endmodule
